flit_input_buffer: RTL and testbench

- Per-port input FIFO placed directly upstream of each input of the N-to-1 priority reductor; one instance per reductor input.
- Absorbs flits from the link, checks packet framing (head/body/tail/single), and presents the oldest flit to the reductor with the same valid/avail handshake.
- Ages the priority (CMP) field of a stalled head flit so that losing packets eventually win arbitration.

---
 rtl/flit_input_buffer_pkg.sv | 9 +
 rtl/para.sv | 22 ++
 rtl/flit_input_buffer_if.sv | 21 ++
 rtl/flit_input_buffer_fifo_mem.sv | 25 ++
 rtl/flit_input_buffer.sv | 150 +++++++++++++++
 tb/tb_flit_input_buffer.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/flit_input_buffer_pkg.sv
// Types local to the flit input buffer.
package flit_input_buffer_pkg;
    typedef logic [para::FLIT_SIZE-1:0] flit_t;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_IN_PKT = 1'b1
    } rx_state_t;
endpackage

// File: rtl/para.sv
// Shared flit format constants and header helpers, common to the input buffers
// and the priority reductor.
package para;
    localparam int FLIT_SIZE  = 32;
    localparam int HEADER_LEN = 2;
    localparam int CMP_POS    = 29;
    localparam int CMP_LEN    = 4;

    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00;
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b01;
    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b10;
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

    function automatic logic [HEADER_LEN-1:0] flit_type(input logic [FLIT_SIZE-1:0] f);
        return f[FLIT_SIZE-1 -: HEADER_LEN];
    endfunction

    // A flit that opens a packet and therefore carries a meaningful priority.
    function automatic logic is_head(input logic [FLIT_SIZE-1:0] f);
        return (flit_type(f) == HEAD_FLIT) || (flit_type(f) == SINGLE_FLIT);
    endfunction
endpackage

// File: rtl/flit_input_buffer_if.sv
// Link-side and reductor-side valid/avail handshake of one flit input buffer.
interface flit_input_buffer_if;
    import flit_input_buffer_pkg::*;

    flit_t in;
    logic  in_valid;
    logic  in_avail;
    flit_t out;
    logic  out_valid;
    logic  out_avail;

    modport master (
        output in, in_valid, out_avail,
        input  in_avail, out, out_valid
    );

    modport slave (
        input  in, in_valid, out_avail,
        output in_avail, out, out_valid
    );
endinterface

// File: rtl/flit_input_buffer_fifo_mem.sv
// Flit storage array: synchronous write, asynchronous read for fall-through.
module flit_fifo_mem
    import flit_input_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  flit_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output flit_t                    rdata
);

    flit_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flit_input_buffer.sv
// Per-input FIFO ahead of the priority reductor: framing check on entry and
// priority aging of a stalled head flit on exit.
module flit_input_buffer
    import para::*;
    import flit_input_buffer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int AGE_PERIOD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    flit_input_buffer_if.slave       link,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     proto_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int AGE_W = $clog2(AGE_PERIOD + 1);

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          count;
    logic [AGE_W-1:0]     age_cnt;
    logic [CMP_LEN-1:0]   age_off;
    rx_state_t            rx_state;
    rx_state_t            rx_next;
    logic                 accept;
    logic                 store;
    logic                 err_set;
    logic                 pop;
    logic                 stall;
    flit_t                front;
    flit_t                aged;

    function automatic logic [CMP_LEN-1:0] sat_add(input logic [CMP_LEN-1:0] a,
                                                   input logic [CMP_LEN-1:0] b);
        logic [CMP_LEN:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CMP_LEN] ? {CMP_LEN{1'b1}} : s[CMP_LEN-1:0];
    endfunction

    // Extra pointer MSB makes count == DEPTH distinguishable from empty.
    assign count = wr_ptr - rd_ptr;

    always_comb begin
        link.in_avail  = rst && !count[AW];
        link.out_valid = rst && (count != '0);
        occupancy      = rst ? count : '0;
    end

    assign accept = link.in_valid && link.in_avail;
    assign pop    = link.out_valid && link.out_avail;
    assign stall  = link.out_valid && !link.out_avail && is_head(front);

    // Framing check: a rejected flit still completes its handshake.
    always_comb begin
        rx_next = rx_state;
        store   = 1'b0;
        err_set = 1'b0;
        if (accept) begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (flit_type(link.in) == HEAD_FLIT) begin
                        store   = 1'b1;
                        rx_next = RX_IN_PKT;
                    end else if (flit_type(link.in) == SINGLE_FLIT) begin
                        store   = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                RX_IN_PKT: begin
                    if (flit_type(link.in) == BODY_FLIT) begin
                        store   = 1'b1;
                    end else if (flit_type(link.in) == TAIL_FLIT) begin
                        store   = 1'b1;
                        rx_next = RX_IDLE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    flit_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (link.in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (front)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Aging restarts whenever the front flit leaves or is not a packet head.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age_cnt <= '0;
            age_off <= '0;
        end else if (stall) begin
            if (age_cnt == AGE_W'(AGE_PERIOD - 1)) begin
                age_cnt <= '0;
                if (age_off != {CMP_LEN{1'b1}}) begin
                    age_off <= age_off + CMP_LEN'(1);
                end
            end else begin
                age_cnt <= age_cnt + AGE_W'(1);
            end
        end else begin
            age_cnt <= '0;
            age_off <= '0;
        end
    end

    always_comb begin
        aged                        = front;
        aged[CMP_POS -: CMP_LEN]    = sat_add(front[CMP_POS -: CMP_LEN], age_off);
        link.out                    = rst ? aged : '0;
    end

endmodule

// File: tb/tb_flit_input_buffer.sv
// Bench for flit_input_buffer: framing table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_flit_input_buffer;
    import para::*;

    localparam int DEPTH = 8;
    localparam int AGE   = 8;
    localparam int CMAX  = (1 << CMP_LEN) - 1;
    localparam int PLW   = CMP_POS - CMP_LEN + 1;

    typedef logic [FLIT_SIZE-1:0] fl_t;

    typedef struct {
        fl_t f;
        bit  v;
        bit  oa;
        int  occ;
        bit  ia;
        bit  ov;
        bit  err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [$clog2(DEPTH):0] occ;
    logic perr;

    always #5 clk = ~clk;

    flit_input_buffer_if bus ();

    flit_input_buffer #(
        .DEPTH      (DEPTH),
        .AGE_PERIOD (AGE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (bus),
        .occupancy (occ),
        .proto_err (perr)
    );

    int  n_chk  = 0;
    int  n_fail = 0;
    fl_t q[$];
    bit  in_pkt;
    bit  m_err;
    int  stall;
    vec_t tbl[8];

    function automatic fl_t mk(input logic [HEADER_LEN-1:0] t, input int cmp, input int pl);
        fl_t f;
        f = '0;
        f[FLIT_SIZE-1 -: HEADER_LEN] = t;
        f[CMP_POS -: CMP_LEN]        = cmp[CMP_LEN-1:0];
        f[PLW-1:0]                   = pl[PLW-1:0];
        return f;
    endfunction

    function automatic bit m_head(input fl_t f);
        return (f[FLIT_SIZE-1 -: HEADER_LEN] == HEAD_FLIT) ||
               (f[FLIT_SIZE-1 -: HEADER_LEN] == SINGLE_FLIT);
    endfunction

    // Expected front flit: priority raised by one per full AGE stall cycles.
    function automatic fl_t m_out();
        fl_t f;
        int  off;
        int  c;
        f   = q[0];
        off = m_head(f) ? stall / AGE : 0;
        c   = int'(f[CMP_POS -: CMP_LEN]) + off;
        if (c > CMAX) c = CMAX;
        f[CMP_POS -: CMP_LEN] = c[CMP_LEN-1:0];
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("in_avail",  bus.in_avail,  rst && (q.size() < DEPTH));
        chk("out_valid", bus.out_valid, rst && (q.size() != 0));
        chk("occupancy", occ,           rst ? q.size() : 0);
        chk("proto_err", perr,          m_err);
        if (!rst) chk("out_in_reset", bus.out, 0);
        else if (q.size() != 0) chk("out_data", bus.out, m_out());
    endtask

    task automatic model_update(input fl_t f, input bit v, input bit oa);
        bit acc;
        bit pp;
        bit st;
        bit keep;
        logic [HEADER_LEN-1:0] t;
        if (!rst) begin
            q.delete();
            in_pkt = 0;
            m_err  = 0;
            stall  = 0;
        end else begin
            acc  = v && (q.size() < DEPTH);
            pp   = (q.size() != 0) && oa;
            st   = (q.size() != 0) && !oa && m_head(q[0]);
            t    = f[FLIT_SIZE-1 -: HEADER_LEN];
            keep = 0;
            if (acc) begin
                if (!in_pkt) begin
                    if (t == HEAD_FLIT) begin keep = 1; in_pkt = 1; end
                    else if (t == SINGLE_FLIT) keep = 1;
                    else m_err = 1;
                end else begin
                    if (t == BODY_FLIT) keep = 1;
                    else if (t == TAIL_FLIT) begin keep = 1; in_pkt = 0; end
                    else m_err = 1;
                end
            end
            if (pp) void'(q.pop_front());
            if (keep) q.push_back(f);
            stall = st ? stall + 1 : 0;
        end
    endtask

    task automatic cyc(input fl_t f, input bit v, input bit oa, input bit r = 1'b1);
        @(negedge clk);
        rst          = r;
        bus.in       = f;
        bus.in_valid = v;
        bus.out_avail = oa;
        #1;
        compare_model();
        @(posedge clk);
        model_update(f, v, oa);
    endtask

    task automatic do_reset();
        cyc('0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_avail = 1'b0;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        q.delete(); in_pkt = 0; m_err = 0; stall = 0;
        #1;
        chk("rst_in_avail",  bus.in_avail,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occupancy", occ,           0);
        chk("rst_out",       bus.out,       0);
        chk("rst_proto_err", perr,          0);

        // Latency: pushed at edge t, visible in cycle t+1.
        do_reset();
        cyc(mk(SINGLE_FLIT, 5, 'h1234), 1, 0);
        #1;
        chk("lat_out_valid", bus.out_valid, 1);
        chk("lat_out",       bus.out,       mk(SINGLE_FLIT, 5, 'h1234));

        // Framing table.
        tbl[0] = '{mk(BODY_FLIT,   0, 1), 1, 0, 0, 1, 0, 1};
        tbl[1] = '{mk(HEAD_FLIT,   2, 2), 1, 0, 1, 1, 1, 1};
        tbl[2] = '{mk(HEAD_FLIT,   2, 3), 1, 0, 1, 1, 1, 1};
        tbl[3] = '{mk(BODY_FLIT,   0, 4), 1, 0, 2, 1, 1, 1};
        tbl[4] = '{mk(TAIL_FLIT,   0, 5), 1, 0, 3, 1, 1, 1};
        tbl[5] = '{'0,                    0, 1, 2, 1, 1, 1};
        tbl[6] = '{'0,                    0, 1, 1, 1, 1, 1};
        tbl[7] = '{'0,                    0, 1, 0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].f, tbl[i].v, tbl[i].oa);
            #1;
            chk($sformatf("frm%0d_occ", i),  occ,           tbl[i].occ);
            chk($sformatf("frm%0d_ia", i),   bus.in_avail,  tbl[i].ia);
            chk($sformatf("frm%0d_ov", i),   bus.out_valid, tbl[i].ov);
            chk($sformatf("frm%0d_err", i),  perr,          tbl[i].err);
        end

        // Fill and drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(mk(SINGLE_FLIT, 1, 100 + i), 1, 0);
        #1;
        chk("full_occ", occ,          DEPTH);
        chk("full_ia",  bus.in_avail, 0);
        cyc(mk(SINGLE_FLIT, 1, 999), 1, 0);
        #1;
        chk("full_refuse_occ", occ, DEPTH);
        chk("drain_first", bus.out[PLW-1:0], 100);
        for (int i = 0; i < DEPTH; i++) begin
            cyc('0, 0, 1);
            #1;
            if (i < DEPTH - 1) chk($sformatf("drain%0d", i + 1), bus.out[PLW-1:0], 101 + i);
        end
        chk("drain_ov", bus.out_valid, 0);
        chk("drain_ia", bus.in_avail,  1);

        // Concurrent push/pop across pointer wrap.
        do_reset();
        cyc(mk(SINGLE_FLIT, 0, 0), 1, 1);
        for (int i = 1; i <= 20; i++) begin
            cyc(mk(SINGLE_FLIT, 0, i), 1, 1);
            #1;
            chk($sformatf("wrap%0d_occ", i), occ,              1);
            chk($sformatf("wrap%0d_dat", i), bus.out[PLW-1:0], i);
        end
        cyc('0, 0, 1);

        // Aging of a stalled head, then release.
        do_reset();
        cyc(mk(HEAD_FLIT, 3, 77), 1, 0);
        #1;
        chk("age0", bus.out[CMP_POS -: CMP_LEN], 3);
        for (int i = 1; i <= 24; i++) begin
            if (i == 1) cyc(mk(TAIL_FLIT, 7, 78), 1, 0);
            else        cyc('0, 0, 0);
            #1;
            if (i == 8)  chk("age8",  bus.out[CMP_POS -: CMP_LEN], 4);
            if (i == 16) chk("age16", bus.out[CMP_POS -: CMP_LEN], 5);
            if (i == 24) chk("age24", bus.out[CMP_POS -: CMP_LEN], 6);
        end
        cyc('0, 0, 1);
        #1;
        chk("age_next_raw", bus.out, mk(TAIL_FLIT, 7, 78));
        cyc('0, 0, 1);

        do_reset();
        cyc(mk(SINGLE_FLIT, CMAX, 9), 1, 0);
        repeat (10) cyc('0, 0, 0);
        #1;
        chk("age_sat", bus.out[CMP_POS -: CMP_LEN], CMAX);

        // Reset in the middle of a packet.
        do_reset();
        cyc(mk(HEAD_FLIT, 1, 1), 1, 0);
        cyc(mk(BODY_FLIT, 0, 2), 1, 0);
        cyc('0, 0, 0, 1'b0);
        #1;
        chk("midrst_occ", occ,           0);
        chk("midrst_ov",  bus.out_valid, 0);
        chk("midrst_err", perr,          0);
        cyc(mk(BODY_FLIT, 0, 3), 1, 0);
        #1;
        chk("midrst_body_err", perr, 1);
        chk("midrst_body_occ", occ,  0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [HEADER_LEN-1:0] t;
            r = $urandom_range(0, 9);
            if (r <= 2)      t = SINGLE_FLIT;
            else if (r <= 4) t = HEAD_FLIT;
            else if (r <= 7) t = BODY_FLIT;
            else             t = TAIL_FLIT;
            cyc(mk(t, $urandom_range(0, CMAX), $urandom),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 299) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
